// File: rtl/mcc_xbar_seq.sv
// Diagonal sequencer for the memristor crossbar: buffers b/x, programs and senses
// each diagonal, accumulates per-row ADC samples with saturation, and emits y.

module mcc_xbar_lane #(
  parameter int LANE   = 0,
  parameter int DIM_W  = 5,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en_i,
  input  logic              acc_en_i,
  input  logic              last_i,
  input  logic              sel_en_i,
  input  logic [DIM_W-1:0]  d_i,
  input  logic [DATA_W-1:0] adc_i,
  output logic [DIM_W-1:0]  mux_sel_o,
  output logic [ACC_W-1:0]  y_o
);
  logic [DATA_W-1:0] adc_q;
  logic [ACC_W-1:0]  acc_q, y_q, sat;
  logic [ACC_W:0]    sum;

  assign sum = {1'b0, acc_q} + {1'b0, ACC_W'(adc_q)};
  assign sat = sum[ACC_W] ? '1 : sum[ACC_W-1:0];

  // Diagonal d pairs row i with column (i + d) mod N; the narrow add wraps for free.
  assign mux_sel_o = sel_en_i ? (DIM_W'(LANE) + d_i) : '0;
  assign y_o       = y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      adc_q <= '0;
      acc_q <= '0;
      y_q   <= '0;
    end else begin
      if (cap_en_i) adc_q <= adc_i;
      if (acc_en_i) begin
        if (last_i) begin
          y_q   <= sat;
          acc_q <= '0;
        end else begin
          acc_q <= sat;
        end
      end
    end
  end
endmodule

module mcc_xbar_seq #(
  parameter int XBAR_SIZE      = 32,
  parameter int XBAR_DIM_WIDTH = 5,
  parameter int DATA_WIDTH     = 8,
  parameter int ACC_WIDTH      = 12,
  parameter int PROG_CYCLES    = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [XBAR_SIZE*DATA_WIDTH-1:0]     x_values_in,
  input  logic                                x_valid_in,
  input  logic [DATA_WIDTH-1:0]               b_value_in,
  input  logic [XBAR_DIM_WIDTH-1:0]           b_offset_in,
  input  logic                                b_valid_in,
  input  logic [XBAR_DIM_WIDTH-1:0]           diag_in,
  input  logic                                diag_go_in,
  input  logic                                diag_last_in,
  output logic                                busy_out,
  output logic [XBAR_SIZE*DATA_WIDTH-1:0]     dac_out,
  output logic                                dac_valid_out,
  output logic                                dac_mode_out,
  output logic [XBAR_SIZE*XBAR_DIM_WIDTH-1:0] mux_sel,
  input  logic [XBAR_SIZE*DATA_WIDTH-1:0]     adc_in,
  input  logic                                adc_valid_in,
  output logic [XBAR_SIZE*ACC_WIDTH-1:0]      y_values_out,
  output logic                                y_values_valid
);
  localparam int CNT_W = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, PROG, SENSE, ACC, DONE} state_t;

  state_t                                    state_q, state_d;
  logic [CNT_W-1:0]                          cnt_q, cnt_d;
  logic [XBAR_DIM_WIDTH-1:0]                 d_q;
  logic                                      last_q, busy_q;
  logic [XBAR_SIZE-1:0][DATA_WIDTH-1:0]      b_buf_q, x_q;
  logic [XBAR_SIZE-1:0][XBAR_DIM_WIDTH-1:0]  mux_vec;
  logic [XBAR_SIZE-1:0][ACC_WIDTH-1:0]       y_vec;
  logic                                      in_prog, in_sense, in_idle;

  assign in_idle  = (state_q == IDLE);
  assign in_prog  = (state_q == PROG);
  assign in_sense = (state_q == SENSE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (diag_go_in) begin
        state_d = PROG;
        cnt_d   = '0;
      end
      PROG: begin
        if (cnt_q == CNT_W'(PROG_CYCLES - 1)) state_d = SENSE;
        else                                  cnt_d   = cnt_q + CNT_W'(1);
      end
      SENSE:   if (adc_valid_in) state_d = ACC;
      ACC:     state_d = last_q ? DONE : IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      b_buf_q <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      // Loads land on the same edge as go, so PROG already sees them.
      if (in_idle) begin
        if (b_valid_in) b_buf_q[b_offset_in] <= b_value_in;
        if (x_valid_in) x_q <= x_values_in;
        if (diag_go_in) begin
          d_q    <= diag_in;
          last_q <= diag_last_in;
        end
      end
    end
  end

  for (genvar g = 0; g < XBAR_SIZE; g++) begin : g_lane
    mcc_xbar_lane #(
      .LANE   (g),
      .DIM_W  (XBAR_DIM_WIDTH),
      .DATA_W (DATA_WIDTH),
      .ACC_W  (ACC_WIDTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .cap_en_i  (in_sense && adc_valid_in),
      .acc_en_i  (state_q == ACC),
      .last_i    (last_q),
      .sel_en_i  (in_prog || in_sense),
      .d_i       (d_q),
      .adc_i     (adc_in[g*DATA_WIDTH +: DATA_WIDTH]),
      .mux_sel_o (mux_vec[g]),
      .y_o       (y_vec[g])
    );
  end

  assign busy_out       = busy_q;
  assign dac_valid_out  = in_prog || in_sense;
  assign dac_mode_out   = in_sense;
  assign dac_out        = in_prog ? b_buf_q : (in_sense ? x_q : '0);
  assign mux_sel        = mux_vec;
  assign y_values_out   = y_vec;
  assign y_values_valid = (state_q == DONE);
endmodule

// File: tb/tb_mcc_xbar_seq.sv
// Randomized self-checking bench for mcc_xbar_seq against a per-diagonal reference model.

module tb_mcc_xbar_seq;
  localparam int N = 4, DIM = 2, DW = 8, AW = 10, PC = 3;
  localparam int YMAX = (1 << AW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*DW-1:0]   x_values_in, dac_out, adc_in;
  logic              x_valid_in, b_valid_in, diag_go_in, diag_last_in, adc_valid_in;
  logic [DW-1:0]     b_value_in;
  logic [DIM-1:0]    b_offset_in, diag_in;
  logic              busy_out, dac_valid_out, dac_mode_out, y_values_valid;
  logic [N*DIM-1:0]  mux_sel;
  logic [N*AW-1:0]   y_values_out;

  int n_chk = 0, n_pass = 0;
  int b_m[N], x_m[N], y_m[N], yo_m[N];

  mcc_xbar_seq #(.XBAR_SIZE(N), .XBAR_DIM_WIDTH(DIM), .DATA_WIDTH(DW),
                 .ACC_WIDTH(AW), .PROG_CYCLES(PC)) dut (
    .clk(clk), .rst(rst), .x_values_in(x_values_in), .x_valid_in(x_valid_in),
    .b_value_in(b_value_in), .b_offset_in(b_offset_in), .b_valid_in(b_valid_in),
    .diag_in(diag_in), .diag_go_in(diag_go_in), .diag_last_in(diag_last_in),
    .busy_out(busy_out), .dac_out(dac_out), .dac_valid_out(dac_valid_out),
    .dac_mode_out(dac_mode_out), .mux_sel(mux_sel), .adc_in(adc_in),
    .adc_valid_in(adc_valid_in), .y_values_out(y_values_out), .y_values_valid(y_values_valid));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] pack8(input int v[N]);
    logic [63:0] r = '0;
    for (int i = 0; i < N; i++) r |= 64'(v[i] & 8'hff) << (i * DW);
    return r;
  endfunction

  function automatic logic [63:0] pack_y(input int v[N]);
    logic [63:0] r = '0;
    for (int i = 0; i < N; i++) r |= 64'(v[i]) << (i * AW);
    return r;
  endfunction

  function automatic logic [63:0] exp_mux(input int d);
    logic [63:0] r = '0;
    for (int i = 0; i < N; i++) r |= 64'((i + d) % N) << (i * DIM);
    return r;
  endfunction

  task automatic quiet();
    b_valid_in = 0; x_valid_in = 0; diag_go_in = 0; adc_valid_in = 0;
  endtask

  // Random traffic that must have no effect while the block is busy.
  task automatic noise(input bit en, input bit adc_ok);
    quiet();
    if (en) begin
      b_valid_in  = 1'($urandom); b_offset_in = DIM'($urandom); b_value_in = DW'($urandom);
      x_valid_in  = 1'($urandom); x_values_in = {$urandom};
      diag_go_in  = 1'($urandom);
      if (adc_ok) adc_valid_in = 1'($urandom);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin b_m[i] = 0; x_m[i] = 0; y_m[i] = 0; yo_m[i] = 0; end
  endtask

  task automatic load_b(input int off, input int val);
    b_valid_in = 1; b_offset_in = DIM'(off); b_value_in = DW'(val);
    b_m[off] = val & 8'hff;
    @(negedge clk);
    b_valid_in = 0;
  endtask

  task automatic load_x(input int v[N]);
    x_valid_in = 1; x_values_in = pack8(v)[N*DW-1:0];
    for (int i = 0; i < N; i++) x_m[i] = v[i] & 8'hff;
    @(negedge clk);
    x_valid_in = 0;
  endtask

  // Called at a negedge while idle; returns at a negedge in the following IDLE cycle.
  task automatic run_diag(input int d, input bit lst, input int wt, input int adc[N],
                          input bit nz, input bit bw, input int bw_off, input int bw_val);
    diag_in = DIM'(d); diag_last_in = lst; diag_go_in = 1;
    if (bw) begin
      b_valid_in = 1; b_offset_in = DIM'(bw_off); b_value_in = DW'(bw_val);
      b_m[bw_off] = bw_val & 8'hff;
    end
    @(negedge clk);
    for (int k = 0; k < PC; k++) begin
      noise(nz, 1'b1);
      chk("prog_busy", 64'(busy_out), 64'd1);
      chk("prog_dv",   64'(dac_valid_out), 64'd1);
      chk("prog_mode", 64'(dac_mode_out), 64'd0);
      chk("prog_dac",  64'(dac_out), pack8(b_m));
      chk("prog_mux",  64'(mux_sel), exp_mux(d));
      @(negedge clk);
    end
    for (int w = 0; w <= wt; w++) begin
      noise(nz, 1'b0);
      chk("sense_mode", 64'(dac_mode_out), 64'd1);
      chk("sense_dac",  64'(dac_out), pack8(x_m));
      chk("sense_mux",  64'(mux_sel), exp_mux(d));
      if (w == wt) begin
        adc_valid_in = 1; adc_in = pack8(adc)[N*DW-1:0];
      end
      @(negedge clk);
    end
    noise(nz, 1'b1);
    adc_in = {$urandom};
    chk("acc_dv",   64'(dac_valid_out), 64'd0);
    chk("acc_busy", 64'(busy_out), 64'd1);
    chk("acc_yv",   64'(y_values_valid), 64'd0);
    for (int i = 0; i < N; i++) y_m[i] = (y_m[i] + adc[i] > YMAX) ? YMAX : y_m[i] + adc[i];
    if (lst) begin
      for (int i = 0; i < N; i++) begin yo_m[i] = y_m[i]; y_m[i] = 0; end
    end
    @(negedge clk);
    quiet();
    if (lst) begin
      chk("done_yv", 64'(y_values_valid), 64'd1);
      chk("done_y",  64'(y_values_out), pack_y(yo_m));
      chk("done_dac", 64'(dac_out), 64'd0);
      @(negedge clk);
    end
    chk("idle_busy", 64'(busy_out), 64'd0);
    chk("idle_yv",   64'(y_values_valid), 64'd0);
    chk("idle_y",    64'(y_values_out), pack_y(yo_m));
  endtask

  task automatic go(input int d, input bit lst, input int wt, input int adc[N]);
    run_diag(d, lst, wt, adc, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    int a[N], v[N];
    rst = 1; quiet();
    x_values_in = '0; b_value_in = '0; b_offset_in = '0;
    diag_in = '0; diag_last_in = 0; adc_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_dv",   64'(dac_valid_out), 64'd0);
    chk("rst_dac",  64'(dac_out), 64'd0);
    chk("rst_mux",  64'(mux_sel), 64'd0);
    chk("rst_y",    64'(y_values_out), 64'd0);
    chk("rst_yv",   64'(y_values_valid), 64'd0);

    // single diagonal
    for (int i = 0; i < N; i++) load_b(i, i + 1);
    v = '{5, 6, 7, 8}; load_x(v);
    a = '{10, 20, 30, 40}; go(0, 1, 2, a);
    chk("t1_y", 64'(y_values_out), pack_y('{10, 20, 30, 40}));

    // mux wrap
    a = '{1, 2, 3, 4}; go(3, 1, 0, a);

    // multi-diagonal accumulation
    a = '{5, 5, 5, 5}; go(0, 0, 0, a);
    a = '{7, 7, 7, 7}; go(1, 0, 1, a);
    a = '{9, 9, 9, 9}; go(2, 1, 0, a);
    chk("t3_y", 64'(y_values_out), pack_y('{21, 21, 21, 21}));

    // saturation
    a = '{255, 255, 255, 255};
    for (int k = 0; k < 5; k++) go(k % N, k == 4, 0, a);
    chk("t4_y", 64'(y_values_out), pack_y('{1023, 1023, 1023, 1023}));

    // busy-time noise, then same-cycle b write with go
    a = '{3, 4, 5, 6};
    run_diag(1, 1, 2, a, 1'b1, 1'b0, 0, 0);
    run_diag(2, 1, 0, a, 1'b0, 1'b1, 2, 8'h55);
    chk("t5_b2", 64'(b_m[2]), 64'h55);

    // reset mid-SENSE
    diag_in = 2'd1; diag_last_in = 1; diag_go_in = 1;
    @(negedge clk);
    quiet();
    repeat (PC + 1) @(negedge clk);
    chk("t6_in_sense", 64'(dac_mode_out), 64'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    chk("t6_busy", 64'(busy_out), 64'd0);
    chk("t6_dv",   64'(dac_valid_out), 64'd0);
    chk("t6_mode", 64'(dac_mode_out), 64'd0);
    chk("t6_dac",  64'(dac_out), 64'd0);
    chk("t6_mux",  64'(mux_sel), 64'd0);
    chk("t6_y",    64'(y_values_out), 64'd0);
    chk("t6_yv",   64'(y_values_valid), 64'd0);
    a = '{11, 22, 33, 44}; go(0, 1, 0, a);
    chk("t6_y2", 64'(y_values_out), pack_y('{11, 22, 33, 44}));

    // randomized sequences
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 2) == 0) load_b($urandom_range(0, N - 1), $urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < N; i++) v[i] = $urandom_range(0, 255);
        load_x(v);
      end
      for (int i = 0; i < N; i++) a[i] = $urandom_range(0, 255);
      run_diag($urandom_range(0, N - 1), $urandom_range(0, 3) == 0, $urandom_range(0, 3), a,
               1'($urandom), 1'($urandom), $urandom_range(0, N - 1), $urandom_range(0, 255));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mcc_xbar_seq.md
# mcc_xbar_seq

Parametrised successor of the MCC front end. It buffers one matrix diagonal (b values) and the input vector (x values), then sequences each diagonal through the memristor crossbar: program, sense, accumulate. It drives the crossbar DAC, per-row column mux selects and ADC handshake, accumulates partial products across diagonals, and emits the final y vector. It sits between the host block-streaming logic and the analog crossbar interface.

## Interface
Parameters:
- XBAR_SIZE, 32: crossbar rows/columns N; must equal 2**XBAR_DIM_WIDTH.
- XBAR_DIM_WIDTH, 5: index width for offsets, diagonals and mux selects.
- DATA_WIDTH, 8: width of x, b, DAC and ADC samples.
- ACC_WIDTH, 12: width of each y accumulator; must be at least DATA_WIDTH.
- PROG_CYCLES, 4: cycles the program phase is held; minimum 1.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- x_values_in  in  N*DATA_WIDTH  input vector; element i is at [i*DATA_WIDTH +: DATA_WIDTH].
- x_valid_in  in  1  latch x_values_in.
- b_value_in  in  DATA_WIDTH  one diagonal element.
- b_offset_in  in  XBAR_DIM_WIDTH  row index of b_value_in.
- b_valid_in  in  1  write b_value_in into b_buf[b_offset_in].
- diag_in  in  XBAR_DIM_WIDTH  diagonal index d for the current b_buf contents.
- diag_go_in  in  1  start the program/sense sequence for diag_in.
- diag_last_in  in  1  sampled together with diag_go_in; marks the final diagonal.
- busy_out  out  1  high in any state other than IDLE.
- dac_out  out  N*DATA_WIDTH  crossbar drive values.
- dac_valid_out  out  1  dac_out is being driven.
- dac_mode_out  out  1  0 = program (conductance write), 1 = read (voltage drive).
- mux_sel  out  N*XBAR_DIM_WIDTH  column select for each row.
- adc_in  in  N*DATA_WIDTH  sensed row currents, unsigned.
- adc_valid_in  in  1  adc_in is valid.
- y_values_out  out  N*ACC_WIDTH  final result vector.
- y_values_valid  out  1  one-cycle pulse when y_values_out is updated.

## Operation
- **States:** IDLE, PROG, SENSE, ACC, DONE.
- **Loads:**
  - b and x writes are accepted only in IDLE. They are ignored in all other states.
  - b_buf and x_reg keep their contents across diagonals. The host overwrites only what changes.
- **IDLE → PROG:** on diag_go_in. Latch d = diag_in and last = diag_last_in.
- **Same-cycle load and go:** if b_valid_in or x_valid_in is high in the same IDLE cycle as diag_go_in, the write lands at that edge and PROG uses the updated value.
- **PROG:**
  - dac_valid_out = 1, dac_mode_out = 0, dac_out = b_buf.
  - mux_sel[i] = (i + d) mod N. This is natural wrap in XBAR_DIM_WIDTH bits.
  - The state lasts exactly PROG_CYCLES cycles, counted by an internal counter, then goes to SENSE.
- **SENSE:**
  - dac_valid_out = 1, dac_mode_out = 1, dac_out = x_reg, mux_sel unchanged.
  - Stays in SENSE until adc_valid_in. There is no timeout.
  - Capture adc_in into an internal register on that edge, then go to ACC.
- **ACC (1 cycle):**
  - For each row i: y_acc[i] += zero-extended adc sample [i].
  - Addition saturates at 2**ACC_WIDTH − 1 with no wrap.
  - Go to DONE if last, otherwise to IDLE.
- **DONE (1 cycle):**
  - y_values_out <= y_acc; y_values_valid = 1; all y_acc cleared.
  - Go to IDLE.
- **Signals ignored outside their state:**
  - diag_go_in outside IDLE.
  - adc_valid_in outside SENSE.
- **Outputs outside PROG/SENSE:** dac_valid_out = 0, dac_out = 0, dac_mode_out = 0, mux_sel = 0.
- **Reset values (including reset mid-sequence):**
  - State returns to IDLE. b_buf, x_reg, y_acc, y_values_out and counters all clear to 0.
  - All outputs are 0.
  - An in-flight diagonal is discarded with no y_values_valid.

## Timing
- diag_go_in sampled at edge T0. PROG covers cycles T0+1 … T0+PROG_CYCLES. SENSE starts at T0+PROG_CYCLES+1.
- adc_valid_in sampled at edge Ts. ACC runs in cycle Ts+1. DONE, with y_values_valid high, runs in Ts+2 if last. IDLE is reached in Ts+2 if not last, or Ts+3 if last.
- Minimum back-to-back diagonal period: PROG_CYCLES + 3 cycles, given adc_valid_in in the first SENSE cycle.
- y_values_out holds its value until the next DONE.
- busy_out is registered from state and falls in the first IDLE cycle.

## Test plan
Bench parameters: N=4, XBAR_DIM_WIDTH=2, DATA_WIDTH=8, ACC_WIDTH=10, PROG_CYCLES=3.

1. **Single diagonal.**
   - Stimulus: b = {1,2,3,4}, x = {5,6,7,8}, go with d=0, last=1. ADC returns {10,20,30,40} two cycles into SENSE.
   - Required: dac_mode_out = 0 for exactly 3 cycles with dac_out = b; then dac_out = x; y = {10,20,30,40} with a one-cycle valid pulse.
2. **Mux wrap.**
   - Stimulus: go with d=3.
   - Required: mux_sel = {3,0,1,2} for rows 0..3 during PROG and SENSE.
3. **Multi-diagonal accumulation.**
   - Stimulus: diagonals 0,1,2 with last on 2; ADC returns all-5, then all-7, then all-9.
   - Required: y = {21,21,21,21}; no y_values_valid before the third diagonal.
4. **Saturation.**
   - Stimulus: five diagonals with ADC all-255.
   - Required: y = {1023,1023,1023,1023}, with no wrap.
5. **Ignored and simultaneous inputs.**
   - Stimulus: b_valid_in, x_valid_in, diag_go_in and adc_valid_in pulsed while busy; then b_valid_in (offset 2, value 0x55) in the same IDLE cycle as go.
   - Required: busy-time pulses have no effect; PROG dac_out row 2 = 0x55.
6. **Reset mid-SENSE.**
   - Stimulus: assert rst for 1 cycle.
   - Required: next cycle is IDLE; all outputs 0; no y_values_valid; next single-diagonal run gives y equal to that diagonal's ADC values only.
